// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD counter family.
// Digit width, the largest legal digit and direction encodings live here.
package bcd_pkg;

    localparam int         BCD_W         = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] nib);
        return nib <= BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade stage of the BCD counter.
// Loads, or steps up/down with 9<->0 rollover when enabled.
module bcd_digit
    import bcd_pkg::*;
#(
    parameter logic [BCD_W-1:0] INIT_DIGIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [BCD_W-1:0] ld_digit,
    output logic [BCD_W-1:0] digit,
    output logic             tc_up,
    output logic             tc_dn
);

    logic [BCD_W-1:0] digit_d;
    logic [BCD_W-1:0] digit_q;

    // Next digit: load wins, otherwise step with decade rollover.
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = ld_digit;
        end else if (en) begin
            if (dir == DIR_DOWN) begin
                digit_d = (digit_q == '0) ? BCD_MAX_DIGIT
                                          : digit_q - 1'b1;
            end else begin
                digit_d = (digit_q == BCD_MAX_DIGIT) ? '0
                                                     : digit_q + 1'b1;
            end
        end
    end

    // Digit register with synchronous reset to its initial value.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= INIT_DIGIT;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign tc_up = (digit_q == BCD_MAX_DIGIT);
    assign tc_dn = (digit_q == '0);

endmodule

// File: rtl/bcd_counter_nd.sv
// Multi-digit BCD up/down counter with validated load,
// wrap pulse, sticky overflow and cascade terminal count.
module bcd_counter_nd
    import bcd_pkg::*;
#(
    parameter int                   DIGITS = 4,
    parameter logic [4*DIGITS-1:0]  INIT   = '0
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Cin,
    input  logic                Dir,
    input  logic                Load,
    input  logic [4*DIGITS-1:0] Ld_val,
    input  logic                Ovf_clr,
    output logic [4*DIGITS-1:0] q,
    output logic                Cout,
    output logic                Tc,
    output logic                Ovf,
    output logic                Ld_err
);

    logic [DIGITS-1:0] tc_up;
    logic [DIGITS-1:0] tc_dn;
    logic [DIGITS-1:0] dig_term;
    logic [DIGITS-1:0] en;
    logic              all_term;
    logic              ld_ok;
    logic              ld_go;
    logic              count;
    logic              wrap;

    logic cout_d, cout_q;
    logic ovf_d, ovf_q;
    logic ld_err_d, ld_err_q;

    // A digit is terminal when it would roll over in the current direction.
    assign dig_term = (Dir == DIR_DOWN) ? tc_dn : tc_up;

    // Every nibble of the load value must be a legal decimal digit.
    always_comb begin
        ld_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            ld_ok = ld_ok & bcd_valid(Ld_val[i*BCD_W +: BCD_W]);
        end
    end

    assign ld_go = Load & ld_ok;
    assign count = Cin & ~Load;

    // Ripple enable: digit i steps when all lower digits are terminal.
    always_comb begin
        en       = '0;
        all_term = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            en[i]    = count & all_term;
            all_term = all_term & dig_term[i];
        end
    end

    assign wrap = count & all_term;
    assign Tc   = Cin & all_term;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit #(
            .INIT_DIGIT (INIT[g*BCD_W +: BCD_W])
        ) u_digit (
            .clk      (Clk),
            .rst      (Rst),
            .en       (en[g]),
            .dir      (Dir),
            .load     (ld_go),
            .ld_digit (Ld_val[g*BCD_W +: BCD_W]),
            .digit    (q[g*BCD_W +: BCD_W]),
            .tc_up    (tc_up[g]),
            .tc_dn    (tc_dn[g])
        );
    end

    // Flag next-state: wrap pulse, sticky overflow (set beats clear), load error.
    always_comb begin
        cout_d   = wrap;
        ld_err_d = Load & ~ld_ok;
        ovf_d    = ovf_q;
        if (wrap) begin
            ovf_d = 1'b1;
        end else if (Ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Flag registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign Cout   = cout_q;
    assign Ovf    = ovf_q;
    assign Ld_err = ld_err_q;

endmodule
